// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the seven-segment scan display slice:
// active-low hex segment table, blank pattern and counter width helper.
package seg_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low abcdefg patterns, entry 0 is the rightmost (index 0) element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Page data in, segment/anode drive out, for seg_scan_display.
interface seg_scan_display_if
  import seg_display_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned N_PAGES  = 2
);
  localparam int unsigned PW = width_of(N_PAGES);

  logic [N_PAGES*N_DIGITS*4-1:0] digits_in;
  logic [N_PAGES*N_DIGITS-1:0]   dp_in;
  logic                          page_hold;
  logic [6:0]                    seg;
  logic                          dp;
  logic [N_DIGITS-1:0]           an;
  logic [PW-1:0]                 page_idx;

  modport master (output digits_in, dp_in, page_hold, input seg, dp, an, page_idx);
  modport slave  (input digits_in, dp_in, page_hold, output seg, dp, an, page_idx);
endinterface

// File: rtl/seg_hex_decoder.sv
// 4-bit hex to active-low seven-segment lookup.
module seg_hex_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = HEX_SEG[hex_i];
  end
endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit, multi-page seven-segment scan controller on a single clock.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero one.
module seg_scan_display
  import seg_display_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned N_PAGES      = 2,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int unsigned PAGE_FRAMES  = 250
)(
  input logic              clk,
  input logic              reset,
  seg_scan_display_if.slave bus
);
  localparam int unsigned DW = width_of(REFRESH_DIV);
  localparam int unsigned SW = width_of(N_DIGITS);
  localparam int unsigned FW = width_of(PAGE_FRAMES);
  localparam int unsigned PW = width_of(N_PAGES);
  localparam int unsigned PAGE_BITS = N_DIGITS * 4;

  logic [DW-1:0]        div_q;
  logic [SW-1:0]        scan_q;
  logic [FW-1:0]        frame_q;
  logic [PW-1:0]        page_q;
  logic [PAGE_BITS-1:0] snap_q;
  logic [N_DIGITS-1:0]  snap_dp_q;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [N_DIGITS-1:0]  an_q, an_d;

  logic       slot_end, frame_start, frame_end;
  logic [3:0] digit_sel;
  logic [6:0] digit_seg;
  logic       digit_blank;

  assign slot_end    = (div_q == DW'(REFRESH_DIV - 1));
  assign frame_start = (div_q == '0) && (scan_q == '0);
  assign frame_end   = slot_end && (scan_q == SW'(N_DIGITS - 1));
  assign digit_sel   = snap_q[4*int'(scan_q) +: 4];

  seg_hex_decoder u_dec (
    .hex_i (digit_sel),
    .seg_o (digit_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] upper_zero;
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      acc = acc & (snap_q[4*(N_DIGITS-1-i) +: 4] == 4'h0);
      upper_zero[N_DIGITS-1-i] = acc;
    end
  end
  assign digit_blank = upper_zero[scan_q] && (scan_q != '0);
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (div_q >= DW'(GUARD_CYCLES)) begin
      an_d  = ~(N_DIGITS'(1) << scan_q);
      seg_d = digit_blank ? SEG_BLANK : digit_seg;
      dp_d  = ~snap_dp_q[scan_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      scan_q    <= '0;
      frame_q   <= '0;
      page_q    <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      div_q <= slot_end ? '0 : div_q + 1'b1;
      if (slot_end)
        scan_q <= (scan_q == SW'(N_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      // Page data is sampled only here, so a frame never mixes old and new input.
      if (frame_start) begin
        snap_q    <= bus.digits_in[PAGE_BITS*int'(page_q) +: PAGE_BITS];
        snap_dp_q <= bus.dp_in[N_DIGITS*int'(page_q) +: N_DIGITS];
      end
      if ((N_PAGES > 1) && frame_end && !bus.page_hold) begin
        if (frame_q == FW'(PAGE_FRAMES - 1)) begin
          frame_q <= '0;
          page_q  <= (page_q == PW'(N_PAGES - 1)) ? '0 : page_q + 1'b1;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.an       = an_q;
  assign bus.page_idx = page_q;
endmodule
